// File: rtl/apb2axi_tag_directory.sv
// apb2axi_tag_directory
//
// Transaction directory for the APB-to-AXI gateway. The APB front-end
// allocates descriptors into free slots. The AXI transaction manager pops
// them in allocation order, with no more than MAX_OUTSTANDING in flight, and
// later returns completions. The APB side reads the stored completion
// status and then releases the tag.
//
// Ports
//   pclk, presetn            clock, asynchronous active-low reset
//   alloc_*                  descriptor allocation (valid/ready, tag preview)
//   dir_pop_*                issue head toward the transaction manager
//   dir_cpl_*                completion reports (always accepted)
//   dir_consumed_*           APB releases a completed tag
//   query_*                  combinational status lookup for one tag
//   occupancy, outstanding   non-EMPTY and PENDING entry counts
//   proto_err, proto_err_clr sticky protocol-violation flag and its clear

package apb2axi_dir_pkg;

  localparam int DIR_ENTRIES   = 8;
  localparam int DIR_TAG_MAX_W = 8;

  typedef struct packed {
    logic                     is_write;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic [3:0]               wstrb;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [DIR_TAG_MAX_W-1:0] tag;
  } directory_entry_t;

endpackage

module apb2axi_tag_directory
  import apb2axi_dir_pkg::*;
#(
  parameter int ENTRIES         = DIR_ENTRIES,
  parameter int TAG_W           = $clog2(ENTRIES),
  parameter int MAX_OUTSTANDING = ENTRIES
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   alloc_valid,
  input  directory_entry_t       alloc_entry,
  output logic                   alloc_ready,
  output logic [TAG_W-1:0]       alloc_tag,
  output logic                   dir_pop_valid,
  output directory_entry_t       dir_pop_entry,
  output logic [TAG_W-1:0]       dir_pop_tag,
  input  logic                   dir_pop_ready,
  input  logic                   dir_cpl_valid,
  input  logic [TAG_W-1:0]       dir_cpl_tag,
  input  logic                   dir_cpl_error,
  input  logic [1:0]             dir_cpl_resp,
  input  logic [7:0]             dir_cpl_num_beats,
  output logic                   dir_cpl_ready,
  input  logic                   dir_consumed_valid,
  input  logic [TAG_W-1:0]       dir_consumed_tag,
  input  logic [TAG_W-1:0]       query_tag,
  output logic [1:0]             query_state,
  output logic                   query_error,
  output logic [1:0]             query_resp,
  output logic [7:0]             query_num_beats,
  output logic [TAG_W:0]         occupancy,
  output logic [TAG_W:0]         outstanding,
  output logic                   proto_err,
  input  logic                   proto_err_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ALLOC = 2'd1,
    ST_PEND  = 2'd2,
    ST_CPL   = 2'd3
  } dir_state_e;

  localparam logic [TAG_W:0]   ENTRIES_C = (TAG_W+1)'(ENTRIES);
  localparam logic [TAG_W:0]   MAX_OUT_C = (TAG_W+1)'(MAX_OUTSTANDING);
  localparam logic [TAG_W-1:0] LAST_IDX  = TAG_W'(ENTRIES - 1);

  // Per-entry storage
  dir_state_e       state_r     [ENTRIES];
  dir_state_e       state_nxt_s [ENTRIES];
  directory_entry_t entry_r     [ENTRIES];
  logic             err_r       [ENTRIES];
  logic [1:0]       resp_r      [ENTRIES];
  logic [7:0]       beats_r     [ENTRIES];

  // Issue FIFO of tags in allocation order
  logic [TAG_W-1:0] fifo_r [ENTRIES];
  logic [TAG_W-1:0] rd_ptr_r;
  logic [TAG_W-1:0] wr_ptr_r;
  logic [TAG_W:0]   fifo_cnt_r;

  logic [TAG_W:0]   occ_r;
  logic [TAG_W:0]   outst_r;
  logic             proto_err_r;

  logic             alloc_ready_s;
  logic [TAG_W-1:0] alloc_tag_s;
  logic             pop_valid_s;
  logic [TAG_W-1:0] pop_tag_s;
  logic             alloc_fire_s;
  logic             pop_fire_s;
  logic             cpl_ok_s;
  logic             cons_ok_s;
  logic             proto_set_s;
  directory_entry_t alloc_entry_s;

  // Tags outside 0..ENTRIES-1 can only appear when ENTRIES is not a power of two
  function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
    return ({1'b0, t} < ENTRIES_C);
  endfunction

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == LAST_IDX) ? {TAG_W{1'b0}} : p + TAG_W'(1);
  endfunction

  // Lowest EMPTY index, scanning downward so the lowest match is written last
  always_comb begin
    alloc_tag_s = {TAG_W{1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      alloc_tag_s = (state_r[i] == ST_EMPTY) ? TAG_W'(i) : alloc_tag_s;
    end
  end

  // Handshake qualification; all readiness terms come from registered state
  always_comb begin
    alloc_ready_s = (occ_r < ENTRIES_C);
    pop_valid_s   = (fifo_cnt_r != {(TAG_W+1){1'b0}}) && (outst_r < MAX_OUT_C);
    pop_tag_s     = fifo_r[rd_ptr_r];
    alloc_fire_s  = alloc_valid && alloc_ready_s;
    pop_fire_s    = pop_valid_s && dir_pop_ready;
    if (dir_cpl_valid && tag_in_range(dir_cpl_tag)) begin
      cpl_ok_s = (state_r[dir_cpl_tag] == ST_PEND);
    end else begin
      cpl_ok_s = 1'b0;
    end
    // A completion to the same tag sees PENDING, so this consume fails naturally
    if (dir_consumed_valid && tag_in_range(dir_consumed_tag)) begin
      cons_ok_s = (state_r[dir_consumed_tag] == ST_CPL);
    end else begin
      cons_ok_s = 1'b0;
    end
    proto_set_s = (dir_cpl_valid && !cpl_ok_s) || (dir_consumed_valid && !cons_ok_s);
    alloc_entry_s     = alloc_entry;
    alloc_entry_s.tag = DIR_TAG_MAX_W'(alloc_tag_s);
  end

  // Per-entry next state; the four events always target entries in distinct states
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc_fire_s && (alloc_tag_s == TAG_W'(i))) begin
        state_nxt_s[i] = ST_ALLOC;
      end else if (pop_fire_s && (pop_tag_s == TAG_W'(i))) begin
        state_nxt_s[i] = ST_PEND;
      end else if (cpl_ok_s && (dir_cpl_tag == TAG_W'(i))) begin
        state_nxt_s[i] = ST_CPL;
      end else if (cons_ok_s && (dir_consumed_tag == TAG_W'(i))) begin
        state_nxt_s[i] = ST_EMPTY;
      end else begin
        state_nxt_s[i] = state_r[i];
      end
    end
  end

  // Entry state, descriptor and completion status registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_r[i] <= ST_EMPTY;
        entry_r[i] <= '0;
        err_r[i]   <= 1'b0;
        resp_r[i]  <= 2'd0;
        beats_r[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_r[i] <= state_nxt_s[i];
        if (alloc_fire_s && (alloc_tag_s == TAG_W'(i))) begin
          entry_r[i] <= alloc_entry_s;
        end
        if (cpl_ok_s && (dir_cpl_tag == TAG_W'(i))) begin
          err_r[i]   <= dir_cpl_error;
          resp_r[i]  <= dir_cpl_resp;
          beats_r[i] <= dir_cpl_num_beats;
        end else if (cons_ok_s && (dir_consumed_tag == TAG_W'(i))) begin
          err_r[i]   <= 1'b0;
          resp_r[i]  <= 2'd0;
          beats_r[i] <= 8'd0;
        end
      end
    end
  end

  // Issue FIFO; each ALLOCATED entry owns exactly one slot so it cannot overflow
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        fifo_r[i] <= {TAG_W{1'b0}};
      end
      rd_ptr_r   <= {TAG_W{1'b0}};
      wr_ptr_r   <= {TAG_W{1'b0}};
      fifo_cnt_r <= {(TAG_W+1){1'b0}};
    end else begin
      if (alloc_fire_s) begin
        fifo_r[wr_ptr_r] <= alloc_tag_s;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (pop_fire_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      fifo_cnt_r <= fifo_cnt_r + {{TAG_W{1'b0}}, alloc_fire_s}
                               - {{TAG_W{1'b0}}, pop_fire_s};
    end
  end

  // Occupancy and outstanding counters take the net of same-cycle events
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      occ_r   <= {(TAG_W+1){1'b0}};
      outst_r <= {(TAG_W+1){1'b0}};
    end else begin
      occ_r   <= occ_r + {{TAG_W{1'b0}}, alloc_fire_s} - {{TAG_W{1'b0}}, cons_ok_s};
      outst_r <= outst_r + {{TAG_W{1'b0}}, pop_fire_s} - {{TAG_W{1'b0}}, cpl_ok_s};
    end
  end

  // Sticky protocol-error flag; a new violation beats a same-cycle clear
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      proto_err_r <= 1'b0;
    end else if (proto_set_s) begin
      proto_err_r <= 1'b1;
    end else if (proto_err_clr) begin
      proto_err_r <= 1'b0;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

  // Status lookup; out-of-range tags read as EMPTY with cleared status
  always_comb begin
    if (tag_in_range(query_tag)) begin
      query_state     = state_r[query_tag];
      query_error     = err_r[query_tag];
      query_resp      = resp_r[query_tag];
      query_num_beats = beats_r[query_tag];
    end else begin
      query_state     = ST_EMPTY;
      query_error     = 1'b0;
      query_resp      = 2'd0;
      query_num_beats = 8'd0;
    end
  end

  assign alloc_ready   = alloc_ready_s;
  assign alloc_tag     = alloc_tag_s;
  assign dir_pop_valid = pop_valid_s;
  assign dir_pop_tag   = pop_tag_s;
  assign dir_pop_entry = entry_r[pop_tag_s];
  assign dir_cpl_ready = 1'b1;
  assign occupancy     = occ_r;
  assign outstanding   = outst_r;
  assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_apb2axi_tag_directory.sv
// Directed testbench for apb2axi_tag_directory with ENTRIES=4, MAX_OUTSTANDING=2.
module tb_apb2axi_tag_directory;
  import apb2axi_dir_pkg::*;

  localparam int ENTRIES = 4;
  localparam int TAG_W   = 2;

  logic                   pclk;
  logic                   presetn;
  logic                   alloc_valid;
  directory_entry_t       alloc_entry;
  logic                   alloc_ready;
  logic [TAG_W-1:0]       alloc_tag;
  logic                   dir_pop_valid;
  directory_entry_t       dir_pop_entry;
  logic [TAG_W-1:0]       dir_pop_tag;
  logic                   dir_pop_ready;
  logic                   dir_cpl_valid;
  logic [TAG_W-1:0]       dir_cpl_tag;
  logic                   dir_cpl_error;
  logic [1:0]             dir_cpl_resp;
  logic [7:0]             dir_cpl_num_beats;
  logic                   dir_cpl_ready;
  logic                   dir_consumed_valid;
  logic [TAG_W-1:0]       dir_consumed_tag;
  logic [TAG_W-1:0]       query_tag;
  logic [1:0]             query_state;
  logic                   query_error;
  logic [1:0]             query_resp;
  logic [7:0]             query_num_beats;
  logic [TAG_W:0]         occupancy;
  logic [TAG_W:0]         outstanding;
  logic                   proto_err;
  logic                   proto_err_clr;

  int total = 0;
  int bad   = 0;

  apb2axi_tag_directory #(
    .ENTRIES(ENTRIES), .TAG_W(TAG_W), .MAX_OUTSTANDING(2)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .alloc_valid(alloc_valid), .alloc_entry(alloc_entry),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .dir_pop_valid(dir_pop_valid), .dir_pop_entry(dir_pop_entry),
    .dir_pop_tag(dir_pop_tag), .dir_pop_ready(dir_pop_ready),
    .dir_cpl_valid(dir_cpl_valid), .dir_cpl_tag(dir_cpl_tag),
    .dir_cpl_error(dir_cpl_error), .dir_cpl_resp(dir_cpl_resp),
    .dir_cpl_num_beats(dir_cpl_num_beats), .dir_cpl_ready(dir_cpl_ready),
    .dir_consumed_valid(dir_consumed_valid), .dir_consumed_tag(dir_consumed_tag),
    .query_tag(query_tag), .query_state(query_state),
    .query_error(query_error), .query_resp(query_resp),
    .query_num_beats(query_num_beats),
    .occupancy(occupancy), .outstanding(outstanding),
    .proto_err(proto_err), .proto_err_clr(proto_err_clr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    presetn = 1'b0; alloc_valid = 1'b0; alloc_entry = '0; dir_pop_ready = 1'b0;
    dir_cpl_valid = 1'b0; dir_cpl_tag = 2'd0; dir_cpl_error = 1'b0;
    dir_cpl_resp = 2'd0; dir_cpl_num_beats = 8'd0; dir_consumed_valid = 1'b0;
    dir_consumed_tag = 2'd0; query_tag = 2'd0; proto_err_clr = 1'b0;
    tick(); tick();
    // Reset values
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_pop_valid", 32'(dir_pop_valid), 32'd0);
    chk("rst_pop_tag", 32'(dir_pop_tag), 32'd0);
    chk("rst_cpl_ready", 32'(dir_cpl_ready), 32'd1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_outst", 32'(outstanding), 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
    chk("rst_qstate", 32'(query_state), 32'd0);
    presetn = 1'b1;
    tick();

    // Four allocations, tags 0..3; supplied .tag is garbage and must be overwritten
    for (int k = 0; k < 4; k++) begin
      chk("alloc_tag_seq", 32'(alloc_tag), 32'(k));
      chk("alloc_ready_seq", 32'(alloc_ready), 32'd1);
      alloc_valid = 1'b1;
      alloc_entry = '0;
      alloc_entry.addr = 32'h100 + 32'(k);
      alloc_entry.tag = 8'hFF;
      tick();
      if (k == 0) begin
        chk("pop_latency_valid", 32'(dir_pop_valid), 32'd1);
        chk("pop_head_tag", 32'(dir_pop_tag), 32'd0);
        chk("pop_head_addr", dir_pop_entry.addr, 32'h100);
        chk("pop_head_entry_tag", 32'(dir_pop_entry.tag), 32'd0);
      end
    end
    alloc_valid = 1'b0;
    chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd4);

    // Pops capped at two outstanding
    dir_pop_ready = 1'b1;
    chk("pop0_valid", 32'(dir_pop_valid), 32'd1);
    chk("pop0_tag", 32'(dir_pop_tag), 32'd0);
    tick();
    chk("pop1_valid", 32'(dir_pop_valid), 32'd1);
    chk("pop1_tag", 32'(dir_pop_tag), 32'd1);
    chk("pop1_addr", dir_pop_entry.addr, 32'h101);
    tick();
    chk("cap_pop_valid", 32'(dir_pop_valid), 32'd0);
    chk("cap_outst", 32'(outstanding), 32'd2);
    query_tag = 2'd0;
    #1;
    chk("q0_pending", 32'(query_state), 32'd2);

    // Complete tag 1 with status
    dir_cpl_valid = 1'b1; dir_cpl_tag = 2'd1; dir_cpl_error = 1'b1;
    dir_cpl_resp = 2'd2; dir_cpl_num_beats = 8'd5;
    tick();
    dir_cpl_valid = 1'b0; dir_cpl_error = 1'b0; dir_cpl_resp = 2'd0; dir_cpl_num_beats = 8'd0;
    query_tag = 2'd1;
    #1;
    chk("q1_state", 32'(query_state), 32'd3);
    chk("q1_resp", 32'(query_resp), 32'd2);
    chk("q1_err", 32'(query_error), 32'd1);
    chk("q1_beats", 32'(query_num_beats), 32'd5);
    chk("cpl_outst", 32'(outstanding), 32'd1);
    chk("pop2_valid", 32'(dir_pop_valid), 32'd1);
    chk("pop2_tag", 32'(dir_pop_tag), 32'd2);
    tick();
    chk("pop2_done_valid", 32'(dir_pop_valid), 32'd0);
    chk("pop2_outst", 32'(outstanding), 32'd2);

    // Consume tag 1, then reallocate: lowest free is 1
    dir_consumed_valid = 1'b1; dir_consumed_tag = 2'd1;
    tick();
    dir_consumed_valid = 1'b0;
    chk("cons_occ", 32'(occupancy), 32'd3);
    chk("cons_qstate", 32'(query_state), 32'd0);
    chk("cons_qresp", 32'(query_resp), 32'd0);
    chk("cons_alloc_tag", 32'(alloc_tag), 32'd1);
    alloc_valid = 1'b1; alloc_entry = '0; alloc_entry.addr = 32'h200;
    tick();
    alloc_valid = 1'b0;
    chk("realloc_occ", 32'(occupancy), 32'd4);

    // Free outstanding budget; issue continues with 3, then 1
    dir_cpl_valid = 1'b1; dir_cpl_tag = 2'd0; dir_cpl_num_beats = 8'd1;
    tick();
    dir_cpl_valid = 1'b0;
    chk("pop3_tag", 32'(dir_pop_tag), 32'd3);
    chk("pop3_valid", 32'(dir_pop_valid), 32'd1);
    tick();
    dir_cpl_valid = 1'b1; dir_cpl_tag = 2'd2;
    tick();
    dir_cpl_valid = 1'b0;
    chk("pop1b_tag", 32'(dir_pop_tag), 32'd1);
    chk("pop1b_addr", dir_pop_entry.addr, 32'h200);
    chk("pop1b_outst", 32'(outstanding), 32'd1);
    // Pop tag 1 and complete tag 3 together: outstanding unchanged
    dir_cpl_valid = 1'b1; dir_cpl_tag = 2'd3;
    tick();
    dir_cpl_valid = 1'b0; dir_pop_ready = 1'b0;
    chk("popcpl_outst", 32'(outstanding), 32'd1);
    chk("popcpl_valid", 32'(dir_pop_valid), 32'd0);
    chk("popcpl_proto", 32'(proto_err), 32'd0);

    // Protocol violations
    dir_consumed_valid = 1'b1; dir_consumed_tag = 2'd2;
    tick();
    dir_consumed_valid = 1'b0;
    chk("cons2_occ", 32'(occupancy), 32'd3);
    dir_cpl_valid = 1'b1; dir_cpl_tag = 2'd2;
    tick();
    dir_cpl_valid = 1'b0;
    query_tag = 2'd2;
    #1;
    chk("cpl_empty_proto", 32'(proto_err), 32'd1);
    chk("cpl_empty_state", 32'(query_state), 32'd0);
    chk("cpl_empty_outst", 32'(outstanding), 32'd1);
    proto_err_clr = 1'b1;
    tick();
    proto_err_clr = 1'b0;
    chk("clr_proto", 32'(proto_err), 32'd0);
    dir_consumed_valid = 1'b1; dir_consumed_tag = 2'd1;
    tick();
    dir_consumed_valid = 1'b0;
    query_tag = 2'd1;
    #1;
    chk("cons_pend_proto", 32'(proto_err), 32'd1);
    chk("cons_pend_state", 32'(query_state), 32'd2);
    chk("cons_pend_occ", 32'(occupancy), 32'd3);
    // Set beats a same-cycle clear
    dir_consumed_valid = 1'b1; proto_err_clr = 1'b1;
    tick();
    dir_consumed_valid = 1'b0; proto_err_clr = 1'b0;
    chk("set_wins", 32'(proto_err), 32'd1);
    proto_err_clr = 1'b1;
    tick();
    proto_err_clr = 1'b0;
    chk("clr_proto2", 32'(proto_err), 32'd0);
    // Completion and consume on the same tag: completion taken, consume rejected
    dir_cpl_valid = 1'b1; dir_cpl_tag = 2'd1;
    dir_consumed_valid = 1'b1; dir_consumed_tag = 2'd1;
    tick();
    dir_cpl_valid = 1'b0; dir_consumed_valid = 1'b0;
    chk("samtag_state", 32'(query_state), 32'd3);
    chk("samtag_proto", 32'(proto_err), 32'd1);
    chk("samtag_outst", 32'(outstanding), 32'd0);
    chk("samtag_occ", 32'(occupancy), 32'd3);
    proto_err_clr = 1'b1;
    tick();
    proto_err_clr = 1'b0;

    // Alloc and consume together: freed slot not eligible this cycle
    chk("ac_pre_tag", 32'(alloc_tag), 32'd2);
    alloc_valid = 1'b1; alloc_entry = '0; alloc_entry.addr = 32'h300;
    dir_consumed_valid = 1'b1; dir_consumed_tag = 2'd0;
    tick();
    alloc_valid = 1'b0; dir_consumed_valid = 1'b0;
    query_tag = 2'd2;
    #1;
    chk("ac_occ", 32'(occupancy), 32'd3);
    chk("ac_next_tag", 32'(alloc_tag), 32'd0);
    chk("ac_q2_state", 32'(query_state), 32'd1);
    chk("ac_pop_tag", 32'(dir_pop_tag), 32'd2);
    chk("ac_proto", 32'(proto_err), 32'd0);

    // Mid-burst reset
    dir_consumed_valid = 1'b1; dir_consumed_tag = 2'd2;
    tick();
    dir_consumed_valid = 1'b0;
    chk("pre_rst_proto", 32'(proto_err), 32'd1);
    alloc_valid = 1'b1; dir_pop_ready = 1'b1;
    #3;
    presetn = 1'b0;
    #1;
    chk("mid_rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("mid_rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("mid_rst_pop_valid", 32'(dir_pop_valid), 32'd0);
    chk("mid_rst_pop_tag", 32'(dir_pop_tag), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_outst", 32'(outstanding), 32'd0);
    chk("mid_rst_proto", 32'(proto_err), 32'd0);
    chk("mid_rst_qstate", 32'(query_state), 32'd0);
    alloc_valid = 1'b0; dir_pop_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
